// File: rtl/tomasulo_pkg.sv
// Shared defaults and types for the Tomasulo register file and its read ports.
package tomasulo_pkg;
  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_NREGS = 32;
  localparam int DEFAULT_NREAD = 2;
  localparam int DEFAULT_TAG_W = 4;
  localparam int AW            = $clog2(DEFAULT_NREGS);

  typedef struct packed {
    logic                     busy;
    logic [DEFAULT_TAG_W-1:0] tag;
  } reg_status_t;
endpackage

// File: rtl/tomasulo_regfile_read_port.sv
// One combinational operand read port: x0 forcing, CDB bypass, then rename status.
module regfile_read_port
  import tomasulo_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic             i_addrZero,
  input  logic [XLEN-1:0]  i_val,
  input  logic             i_busy,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_cdbValid,
  input  logic [TAG_W-1:0] i_cdbTag,
  input  logic [XLEN-1:0]  i_cdbData,
  output logic [XLEN-1:0]  o_data,
  output logic             o_busy,
  output logic [TAG_W-1:0] o_tag
);
  logic w_hit;

  assign w_hit = i_busy && i_cdbValid && (i_cdbTag == i_tag);

  // A result on the CDB this cycle resolves a pending operand without waiting a cycle.
  always_comb begin
    o_data = i_val;
    o_busy = 1'b0;
    o_tag  = '0;
    if (i_addrZero) begin
      o_data = '0;
    end else if (w_hit) begin
      o_data = i_cdbData;
    end else if (i_busy) begin
      o_busy = 1'b1;
      o_tag  = i_tag;
    end
  end
endmodule

// File: rtl/tomasulo_regfile.sv
// Architectural register file with per-register rename status, CDB capture and flush.
module tomasulo_regfile
  import tomasulo_pkg::*;
#(
  parameter  int XLEN   = DEFAULT_XLEN,
  parameter  int NREGS  = DEFAULT_NREGS,
  parameter  int NREAD  = DEFAULT_NREAD,
  parameter  int TAG_W  = DEFAULT_TAG_W,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*XLEN-1:0]   rd_data,
  output logic [NREAD-1:0]        rd_busy,
  output logic [NREAD*TAG_W-1:0]  rd_tag,
  input  logic                    issue_valid,
  input  logic [ADDR_W-1:0]       issue_rd,
  input  logic [TAG_W-1:0]        issue_tag,
  input  logic                    cdb_valid,
  input  logic [TAG_W-1:0]        cdb_tag,
  input  logic [XLEN-1:0]         cdb_data
);
  logic [XLEN-1:0]  r_val [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [TAG_W-1:0] r_tag [NREGS];

  // x0 is only ever touched by reset; the issue assignment comes after the CDB
  // clear so that a same-cycle rename keeps its status while the value is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
      for (int r = 0; r < NREGS; r++) begin
        r_val[r] <= '0;
        r_tag[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (cdb_valid && r_busy[r] && (r_tag[r] == cdb_tag)) begin
          r_val[r]  <= cdb_data;
          r_busy[r] <= 1'b0;
        end
        if (flush) begin
          r_busy[r] <= 1'b0;
        end else if (issue_valid && (issue_rd == ADDR_W'(r))) begin
          r_busy[r] <= 1'b1;
          r_tag[r]  <= issue_tag;
        end
      end
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [ADDR_W-1:0] w_addr;

    assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .XLEN (XLEN),
      .TAG_W(TAG_W)
    ) u_port (
      .i_addrZero(w_addr == '0),
      .i_val     (r_val[w_addr]),
      .i_busy    (r_busy[w_addr]),
      .i_tag     (r_tag[w_addr]),
      .i_cdbValid(cdb_valid),
      .i_cdbTag  (cdb_tag),
      .i_cdbData (cdb_data),
      .o_data    (rd_data[p*XLEN +: XLEN]),
      .o_busy    (rd_busy[p]),
      .o_tag     (rd_tag[p*TAG_W +: TAG_W])
    );
  end
endmodule

// File: doc/tomasulo_regfile.md
Name: tomasulo_regfile

Overview:
- Architectural register file plus register-status (rename tag) table for the Tomasulo core.
- Holds committed values and, per register, a busy bit and producing reservation-station tag.
- Sits between the dispatch stage, which reads source operands and renames destinations, and the common data bus (CDB), which broadcasts results.
- Generalises the plain 2-read/1-write file: parametrised width, depth and read-port count; adds rename state, CDB capture, same-cycle bypass and flush.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; must be a power of 2; AW = log2(NREGS).
- NREAD, 2, number of combinational read ports.
- TAG_W, 4, reservation-station tag width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  clears all busy bits (mispredict recovery); values retained.
- rd_addr  in  NREAD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NREAD*XLEN  operand value, or CDB value when bypassed.
- rd_busy  out  NREAD  1 = operand pending; consumer must wait on rd_tag.
- rd_tag  out  NREAD*TAG_W  producing tag; valid only when rd_busy=1.
- issue_valid  in  1  rename request this cycle.
- issue_rd  in  AW  destination register to rename.
- issue_tag  in  TAG_W  tag of the issuing reservation station.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcasting tag.
- cdb_data  in  XLEN  broadcast result.

Behaviour:
- State per register r: val[r] (XLEN), busy[r], tag[r] (TAG_W).
- Reset: every val = 0, busy = 0, tag = 0. rd_data, rd_busy and rd_tag then read 0 for all addresses.
- Register 0 (x0): val is always 0 and busy is always 0. Issue to r=0 is ignored. CDB never writes x0.
- Read ports are combinational, zero latency, with this priority:
  - addr 0 → data 0, busy 0, tag 0.
  - busy[a] and cdb_valid and cdb_tag == tag[a] → data = cdb_data, busy 0 (bypass).
  - busy[a] → data = val[a], busy 1, tag = tag[a].
  - otherwise → data = val[a], busy 0.
- Reads return pre-issue state. An instruction issuing with rs == rd sees the old producer, not its own tag.
- CDB capture at posedge: for every r ≠ 0 with busy[r] and tag[r] == cdb_tag, set val[r] = cdb_data and busy[r] = 0. Multiple registers may match in one cycle. Non-busy registers ignore the CDB.
- Issue at posedge (issue_valid, issue_rd ≠ 0): busy = 1, tag = issue_tag; val unchanged.
- Simultaneous issue and CDB hit on the same register: val = cdb_data, and busy = 1 / tag = issue_tag (issue wins on status, CDB wins on value).
- Issue with issue_tag == cdb_tag in the same cycle: the new mapping is not cleared by that broadcast.
- Flush: all busy = 0 at posedge. Same-cycle issue is dropped. Same-cycle CDB value capture still applies to matching registers.
- Priority: reset > flush > issue/CDB as above.
- Reset asserted mid-operation clears all state on the next posedge, regardless of other inputs.

Decomposition:
- Shared package tomasulo_pkg holds XLEN, TAG_W defaults, a reg_status_t struct {busy, tag}, and the helper localparam AW.
- One natural sub-module: regfile_read_port, the combinational bypass/mux for one port, instantiated NREAD times by generate.

Test Plan:
- Reset, then read all addresses on both ports → data 0, busy 0.
- issue r5 tag 3; next cycle read r5 → busy 1, tag 3. CDB tag 3 data 0xDEADBEEF: same-cycle read → data 0xDEADBEEF, busy 0. Following cycle → val 0xDEADBEEF, busy 0.
- r7 busy tag 2. Same cycle: issue r7 tag 6 and CDB tag 2 data 0x11. Next cycle → val 0x11, busy 1, tag 6. Then CDB tag 2 → r7 unchanged.
- r1 and r2 both tag 4; CDB tag 4 data 0x55 → both val 0x55, busy 0.
- issue r0 tag 1 → r0 reads 0, busy 0. flush with r3, r9 busy → all busy 0, values retained.
- NREAD=3, XLEN=64, NREGS=64 build: write r63 via issue tag 1 + CDB data 0xFFFF_0000_FFFF_0000 → all three ports read r63 correctly.
